mem_arbiter: RTL and testbench

Shares the single memory port between the core's instruction-fetch path and its load/store path, for the multi-cycle core variant whose memory is unified and may insert wait states. Each requester holds a request, the arbiter grants one at a time, and it sequences a single memory transaction. It returns read data with a one-cycle done pulse. It sits between the core (fetch and data ports) and the RAM, replacing the direct `progMemAddress`/`ramAddress` wiring used by the single-cycle core.

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single unified memory port between the fetch and load/store requesters.
// Optional BUSY-state watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_done,
  output logic            err,
  output logic            busy,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            if_done_q, if_done_d;
  logic            d_done_q, d_done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^32'(TIMEOUT);
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (d_req) begin
          state_d     = ST_BUSY;
          owner_d     = OWN_DATA;
          mem_addr_d  = d_addr;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else if (if_req) begin
          state_d     = ST_BUSY;
          owner_d     = OWN_FETCH;
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          state_d   = ST_RESP;
          if_done_d = (owner_q == OWN_FETCH);
          d_done_d  = (owner_q == OWN_DATA);
          // Stores leave the read-data register untouched
          if ((owner_q == OWN_FETCH) || !mem_we_q) begin
            rdata_d = mem_rdata;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d   = ST_RESP;
          if_done_d = (owner_q == OWN_FETCH);
          d_done_d  = (owner_q == OWN_DATA);
          err_d     = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    mem_req_d = (state_d == ST_BUSY);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_FETCH;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store with waits, priority, timeout/hang, reset abort.
module tb_mem_arbiter;
  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_done;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_done;
  logic            err;
  logic            busy;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  int n_tests;
  int n_fail;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int bad;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dones", 32'({if_done, d_done, err, mem_we}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", if_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single fetch, zero wait states
    if_req    = 1'b1;
    if_addr   = 32'h0000_0100;
    mem_ready = 1'b1;
    mem_rdata = 32'h0050_0093;
    tick();
    check("fetch_busy_req", 32'(mem_req), 32'd1);
    check("fetch_addr", mem_addr, 32'h0000_0100);
    check("fetch_we", 32'(mem_we), 32'd0);
    check("fetch_early_done", 32'(if_done), 32'd0);
    tick();
    check("fetch_done", 32'(if_done), 32'd1);
    check("fetch_rdata", if_rdata, 32'h0050_0093);
    check("fetch_err", 32'(err), 32'd0);
    check("fetch_resp_req", 32'(mem_req), 32'd0);
    if_req = 1'b0;
    tick();
    check("fetch_done_pulse", 32'(if_done), 32'd0);
    check("fetch_idle", 32'(busy), 32'd0);

    // Store with three wait states
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h0000_2004;
    d_wdata   = 32'hDEAD_BEEF;
    mem_ready = 1'b0;
    mem_rdata = 32'h5555_AAAA;
    tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!mem_req || mem_addr != 32'h0000_2004 || mem_wdata != 32'hDEAD_BEEF || !mem_we || d_done)
        bad++;
      mem_ready = (i == 3);
      tick();
    end
    check("store_busy_hold", 32'(bad), 32'd0);
    check("store_done", 32'(d_done), 32'd1);
    check("store_err", 32'(err), 32'd0);
    check("store_rdata_kept", d_rdata, 32'h0050_0093);
    check("store_resp_req", 32'(mem_req), 32'd0);
    d_req     = 1'b0;
    d_we      = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("store_done_pulse", 32'(d_done), 32'd0);

    // Simultaneous requests: data first, then fetch
    if_req    = 1'b1;
    if_addr   = 32'h0000_0040;
    d_req     = 1'b1;
    d_addr    = 32'h0000_0080;
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_1111;
    tick();
    check("both_data_addr", mem_addr, 32'h0000_0080);
    tick();
    check("both_d_done", 32'({d_done, if_done}), 32'b10);
    check("both_d_rdata", d_rdata, 32'h1111_1111);
    d_req     = 1'b0;
    mem_rdata = 32'h2222_2222;
    tick();
    check("both_idle_gap", 32'({busy, d_done}), 32'd0);
    tick();
    check("both_fetch_addr", mem_addr, 32'h0000_0040);
    tick();
    check("both_if_done", 32'({d_done, if_done}), 32'b01);
    check("both_if_rdata", if_rdata, 32'h2222_2222);
    if_req = 1'b0;
    tick();
    check("both_end_idle", 32'(busy), 32'd0);

    // Memory never answers
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h0000_0300;
    mem_ready = 1'b0;
    tick();
`ifdef MEM_ARB_TIMEOUT_EN
    n = 0;
    while (mem_req && n < 50) begin
      n++;
      tick();
    end
    check("to_req_cycles", 32'(n), 32'd4);
    check("to_done", 32'(d_done), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();
    check("to_err_pulse", 32'({err, d_done}), 32'd0);
`else
    n   = 0;
    bad = 0;
    repeat (100) begin
      if (!mem_req || d_done || if_done) bad++;
      n++;
      tick();
    end
    check("hang_cycles", 32'(n), 32'd100);
    check("hang_hold", 32'(bad), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("hang_rst_req", 32'(mem_req), 32'd0);
    d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif

    // Reset in the middle of a BUSY access
    if_req    = 1'b1;
    if_addr   = 32'h0000_0500;
    mem_ready = 1'b0;
    mem_rdata = 32'h7777_7777;
    tick();
    tick();
    check("rb_busy_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rb_rst_req", 32'(mem_req), 32'd0);
    check("rb_rst_busy", 32'(busy), 32'd0);
    if_req = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      tick();
      if (if_done || d_done) bad++;
    end
    check("rb_no_done", 32'(bad), 32'd0);

    // mem_ready pulse while idle
    mem_ready = 1'b1;
    tick();
    check("idle_ready", 32'({busy, mem_req, if_done, d_done}), 32'd0);

    // Normal load after reset, mem_ready also high during RESP
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h0000_0600;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    check("post_addr", mem_addr, 32'h0000_0600);
    tick();
    check("post_done", 32'(d_done), 32'd1);
    check("post_rdata", d_rdata, 32'hCAFE_F00D);
    d_req     = 1'b0;
    mem_rdata = 32'h1234_5678;
    tick();
    check("post_resp_ready", 32'({busy, d_done, mem_req}), 32'd0);
    check("post_rdata_kept", d_rdata, 32'hCAFE_F00D);
    mem_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
